// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings and counter sizing.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  // Bits needed to hold the longest latency count, including the value itself.
  function automatic int cnt_width(input int mult_cycles, input int div_cycles);
    int longest;
    longest = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Combinational signed/unsigned divider with MIPS-style divide-by-zero and overflow results.
module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  localparam logic [WIDTH-1:0] MIN_V  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES_V = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};

  logic             neg_a_s;
  logic             neg_b_s;
  logic [WIDTH-1:0] mag_a_s;
  logic [WIDTH-1:0] mag_b_s;
  logic [WIDTH-1:0] q_mag_s;
  logic [WIDTH-1:0] r_mag_s;

  // Divide magnitudes, then restore signs: quotient truncates toward zero, remainder follows dividend.
  always_comb begin
    neg_a_s = is_signed & dividend[WIDTH-1];
    neg_b_s = is_signed & divisor[WIDTH-1];
    mag_a_s = neg_a_s ? (ZERO_V - dividend) : dividend;
    mag_b_s = neg_b_s ? (ZERO_V - divisor) : divisor;
    q_mag_s = ZERO_V;
    r_mag_s = ZERO_V;
    quo     = ZERO_V;
    rem     = ZERO_V;
    if (divisor == ZERO_V) begin
      quo = ONES_V;
      rem = dividend;
    end else if (is_signed && (dividend == MIN_V) && (divisor == ONES_V)) begin
      quo = MIN_V;
      rem = ZERO_V;
    end else begin
      q_mag_s = mag_a_s / mag_b_s;
      r_mag_s = mag_a_s % mag_b_s;
      quo     = (neg_a_s ^ neg_b_s) ? (ZERO_V - q_mag_s) : q_mag_s;
      rem     = neg_a_s ? (ZERO_V - r_mag_s) : r_mag_s;
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// Multiply/divide unit with architectural HI/LO; results are computed at accept and
// committed after a fixed latency modelled by a down-counter.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int             CW     = cnt_width(MULT_CYCLES, DIV_CYCLES);
  localparam logic [CW-1:0]  MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0]  DIV_N  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0]  CNT_1  = CW'(1);

  mdu_op_e            op_s;
  logic [2*WIDTH-1:0] prod_signed_s;
  logic [2*WIDTH-1:0] prod_unsigned_s;
  logic [WIDTH-1:0]   div_quo_s;
  logic [WIDTH-1:0]   div_rem_s;

  logic               busy_d, busy_q;
  logic [CW-1:0]      cnt_d, cnt_q;
  logic [WIDTH-1:0]   hi_d, hi_q;
  logic [WIDTH-1:0]   lo_d, lo_q;
  logic [WIDTH-1:0]   pend_hi_d, pend_hi_q;
  logic [WIDTH-1:0]   pend_lo_d, pend_lo_q;

  assign op_s = mdu_op_e'(op);

  // Sign-extending to 2*WIDTH before multiplying yields the exact signed product modulo 2^(2*WIDTH).
  assign prod_signed_s   = {{WIDTH{src_a[WIDTH-1]}}, src_a} * {{WIDTH{src_b[WIDTH-1]}}, src_b};
  assign prod_unsigned_s = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};

  mdu_div_core #(.WIDTH(WIDTH)) u_div (
    .dividend  (src_a),
    .divisor   (src_b),
    .is_signed (op_s == MDU_DIV),
    .quo       (div_quo_s),
    .rem       (div_rem_s)
  );

  // Next-state: count down while busy, otherwise decode an accepted request.
  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    if (busy_q) begin
      if (cnt_q == CNT_1) begin
        hi_d   = pend_hi_q;
        lo_d   = pend_lo_q;
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q - CNT_1;
      end
    end else if (start) begin
      case (op_s)
        MDU_MULT: begin
          {pend_hi_d, pend_lo_d} = prod_signed_s;
          cnt_d  = MULT_N;
          busy_d = 1'b1;
        end
        MDU_MULTU: begin
          {pend_hi_d, pend_lo_d} = prod_unsigned_s;
          cnt_d  = MULT_N;
          busy_d = 1'b1;
        end
        MDU_DIV, MDU_DIVU: begin
          pend_lo_d = div_quo_s;
          pend_hi_d = div_rem_s;
          cnt_d     = DIV_N;
          busy_d    = 1'b1;
        end
        MDU_MTHI: hi_d = src_a;
        MDU_MTLO: lo_d = src_a;
        default: begin
        end
      endcase
    end else begin
    end
  end

  // State registers; reset discards any pending result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed scoreboard bench for mdu_hilo: expected HI/LO pushed at issue, popped at completion.
module tb_mdu_hilo;
  import mdu_pkg::*;

  localparam int W = 32;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  mdu_hilo #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Drives one request at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; src_a = 32'h0BAD_F00D; src_b = 32'h0000_0001;
  endtask

  // Counts busy cycles (bounded) starting at the current negedge.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int n);
    exp_t        e;
    int          cnt;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    old_hi = hi;
    old_lo = lo;
    sb_q.push_back('{tag, eh, el, n});
    issue(o, a, b);
    if (n > 0) begin
      check({tag, "_hold"}, {hi, lo}, {old_hi, old_lo});
    end else begin
    end
    wait_idle(cnt);
    e = sb_q.pop_front();
    check({e.tag, "_busy"}, 64'(cnt), 64'(e.cycles));
    check({e.tag, "_hi"}, 64'(hi), 64'(e.hi));
    check({e.tag, "_lo"}, 64'(lo), 64'(e.lo));
  endtask

  initial begin
    int cnt;
    exp_t e;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    reset = 1'b1;
    @(negedge clk);

    run_op("mthi", MDU_MTHI, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'h0000_0000, 0);
    run_op("mtlo", MDU_MTLO, 32'h0000_ABCD, 32'h0, 32'h0000_1234, 32'h0000_ABCD, 0);
    run_op("undef", 3'd6, 32'hDEAD_BEEF, 32'h1, 32'h0000_1234, 32'h0000_ABCD, 0);

    run_op("mult", MDU_MULT, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    run_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5);
    run_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10);
    run_op("divu_z", MDU_DIVU, 32'h0000_0005, 32'h0, 32'h0000_0005, 32'hFFFF_FFFF, 10);
    run_op("div_z", MDU_DIV, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 10);
    run_op("div_pn", MDU_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10);
    run_op("divu", MDU_DIVU, 32'h0000_0064, 32'h7, 32'h0000_0002, 32'h0000_000E, 10);
    run_op("divu_big", MDU_DIVU, 32'hFFFF_FFF9, 32'h2, 32'h0000_0001, 32'h7FFF_FFFC, 10);

    // MTLO arriving during busy cycle 2 must be dropped.
    sb_q.push_back('{"ignore", 32'h0, 32'h6, 5});
    issue(MDU_MULT, 32'h2, 32'h3);
    @(negedge clk);
    start = 1'b1; op = MDU_MTLO; src_a = 32'h55;
    @(negedge clk);
    start = 1'b0;
    wait_idle(cnt);
    e = sb_q.pop_front();
    check({e.tag, "_busy"}, 64'(cnt + 2), 64'(e.cycles));
    check({e.tag, "_hi"}, 64'(hi), 64'(e.hi));
    check({e.tag, "_lo"}, 64'(lo), 64'(e.lo));

    // Asynchronous reset at busy cycle 3 of a DIV aborts it for good.
    issue(MDU_DIV, 32'h0000_0064, 32'h3);
    repeat (2) @(negedge clk);
    check("mid_busy_pre", 64'(busy), 64'(1));
    #2 reset = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_hi", 64'(hi), 64'(0));
    check("abort_lo", 64'(lo), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    check("post_busy", 64'(busy), 64'(0));
    check("post_hilo", {hi, lo}, 64'(0));
    check("sb_empty", 64'(sb_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Parametrised multiply/divide unit with architectural HI/LO registers for the next-generation pipelined MIPS core.
- Sits in the EX stage beside the ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO, models multi-cycle latency with a busy flag, and exposes HI/LO for MFHI/MFLO.
- The pipeline hazard unit stalls on `start | busy` when the next MDU instruction needs the unit.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits; must be ≥ 2.
- MULT_CYCLES, 5, busy cycles for MULT/MULTU; must be ≥ 1.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; must be ≥ 1.

Ports:
- clk  in  1  system clock; rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request qualifier for op.
- op  in  3  operation code; see package.
- src_a  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- src_b  in  WIDTH  rt operand: multiplier or divisor.
- busy  out  1  registered; high while a mult/div is in flight.
- hi  out  WIDTH  architectural HI register.
- lo  out  WIDTH  architectural LO register.

Behaviour:
- Reset (reset=0, asynchronous):
  - busy=0, hi=0, lo=0, counter=0.
  - Pending results are discarded.
  - Reset asserted mid-operation aborts the operation; no commit ever occurs for it.
- Idle: busy=0, counter=0.
- Accept condition: a request is accepted on a rising edge where start=1 and busy=0.
- Requests with start=1 while busy=1 are ignored entirely. This includes MTHI/MTLO. Stalling such requests is the hazard unit's job.
- Undefined op codes are accepted as no-ops; busy stays 0.
- MTHI/MTLO:
  - hi (or lo) <= src_a on the accept edge.
  - busy stays 0; latency 1.
- MULT/MULTU on accept:
  - Capture the 2*WIDTH product into pend_hi/pend_lo (signed or unsigned).
  - counter <= MULT_CYCLES; busy <= 1.
- DIV/DIVU on accept:
  - Capture quotient into pend_lo and remainder into pend_hi.
  - counter <= DIV_CYCLES; busy <= 1.
- Divide semantics:
  - Signed divide truncates toward zero; remainder takes the sign of the dividend.
  - Divisor = 0: pend_lo = all ones, pend_hi = src_a (signed and unsigned).
  - Signed overflow (src_a = MIN, src_b = −1): pend_lo = MIN, pend_hi = 0.
- Busy phase: counter decrements each edge.
- Completion edge (counter==1):
  - hi <= pend_hi; lo <= pend_lo; busy <= 0; counter <= 0.
  - busy is therefore high for exactly N cycles after the accept edge.
  - hi/lo show new values in the first cycle busy reads 0.
- While busy, hi/lo hold their old values. MFHI/MFLO correctness is guaranteed by the external stall.
- Back-to-back: a new start is accepted in the same cycle busy first reads 0.
- Operands are sampled only on the accept edge. Later changes to src_a/src_b have no effect.
- Arithmetic is done once at accept and stored. The counter only models latency; no iterative datapath is required.

Decomposition:
- Package mdu_pkg:
  - op encodings, 3 bits: MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3, MDU_MTHI=4, MDU_MTLO=5.
  - Counter-width function clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
- Sub-module mdu_div_core: combinational signed/unsigned divide including the zero and overflow rules; reused by a later iterative divider.
- Multiply stays inline.

Test Plan:
- Reset and MTHI/MTLO: deassert reset, then MTHI 0x1234 and next cycle MTLO 0xABCD. Required: hi=0x1234, lo=0xABCD; busy never rises.
- MULT signed: src_a=0xFFFFFFFE (−2), src_b=3. Required: busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU: 0xFFFFFFFF × 0xFFFFFFFF. Required: hi=0xFFFFFFFE, lo=0x00000001.
- DIV edge cases:
  - (−7)/2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0.
  - DIVU 5/0: lo=0xFFFFFFFF, hi=5.
  - In all three cases busy lasts 10 cycles.
- Ignore-while-busy: start MULT 2×3, then MTLO 0x55 at busy cycle 2. Required: the MTLO is dropped; final lo=6, hi=0.
- Reset mid-operation: assert reset asynchronously (between clock edges) at busy cycle 3 of a DIV. Required: busy=0, hi=lo=0 immediately; no later commit after release.
